// File: rtl/lanectrl_dly_sequencer_if.sv
// Request/response bundle between the training logic (master) and the delay-line sequencer (slave).
// Handshake: a request is taken on the clock edge where REQ_VALID and REQ_READY are both high.
// Request fields are sampled only at that edge. DONE pulses once per taken request, and ERR is sticky until the next accept.
interface lanectrl_dly_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic       REQ_SEL;
    logic [7:0] REQ_STEPS;
    logic       DONE;
    logic       ERR;

    modport master (
        output REQ_VALID, REQ_OP, REQ_SEL, REQ_STEPS,
        input  REQ_READY, DONE, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_SEL, REQ_STEPS,
        output REQ_READY, DONE, ERR
    );
endinterface

// File: rtl/lanectrl_dly_sequencer.sv
// Drives LANECTRL delay-line LOAD/MOVE pulses for one lane, bracketed by HS_IO_CLK_PAUSE.
// It also tracks the RX and TX tap positions and flags range errors.
module lanectrl_dly_sequencer #(
    parameter int unsigned PAUSE_SETUP = 4,
    parameter int unsigned MOVE_GAP    = 2,
    parameter int unsigned PAUSE_HOLD  = 4,
    parameter int unsigned MAX_TAP     = 127,
    parameter int unsigned LOAD_TAP    = 1
) (
    input  logic                      FAB_CLK,
    input  logic                      RESET_N,
    lanectrl_dly_sequencer_if.slave   req,
    input  logic                      RX_OOR,
    input  logic                      TX_OOR,
    output logic [7:0]                TAP_RX,
    output logic [7:0]                TAP_TX,
    output logic                      DELAY_LINE_SEL,
    output logic                      DELAY_LINE_DIRECTION,
    output logic                      DELAY_LINE_LOAD,
    output logic                      DELAY_LINE_MOVE,
    output logic                      HS_IO_CLK_PAUSE,
    output logic [2:0]                dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PAUSE_ON  = 3'd1,
        S_PULSE     = 3'd2,
        S_GAP       = 3'd3,
        S_PAUSE_OFF = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_INC   = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [3:0] SETUP_C  = 4'(PAUSE_SETUP - 1);
    localparam logic [3:0] GAP_C    = 4'(MOVE_GAP - 1);
    localparam logic [3:0] HOLD_C   = 4'(PAUSE_HOLD - 1);
    localparam logic [7:0] MAXTAP_C = 8'(MAX_TAP);
    localparam logic [7:0] LOADTAP_C = 8'(LOAD_TAP);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [7:0] steps_q;
    logic [1:0] op_q;
    logic       sel_q, dir_q;
    logic       ready_q, done_q, err_q;
    logic       load_q, move_q, pause_q;
    logic [7:0] tap_rx_q, tap_tx_q;

    logic [7:0] tap_sel, tap_d;
    logic       at_limit, oor_sel, gap_end, launch;

    assign tap_sel  = sel_q ? tap_tx_q : tap_rx_q;
    assign at_limit = dir_q ? (tap_sel == MAXTAP_C) : (tap_sel == 8'd0);
    assign oor_sel  = sel_q ? TX_OOR : RX_OOR;
    assign gap_end  = (state_q == S_GAP) && (cnt_q == 4'd0);
    // A pulse slot opens at the end of the setup pause, or at the end of a gap with steps left and no OOR.
    assign launch   = ((state_q == S_PAUSE_ON) && (cnt_q == 4'd0))
                    || (gap_end && (steps_q != 8'd0) && !oor_sel);
    assign tap_d    = (op_q == OP_LOAD) ? LOADTAP_C
                    : (dir_q ? tap_sel + 8'd1 : tap_sel - 8'd1);

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            steps_q  <= 8'd0;
            op_q     <= OP_LOAD;
            sel_q    <= 1'b0;
            dir_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            move_q   <= 1'b0;
            pause_q  <= 1'b0;
            tap_rx_q <= LOADTAP_C;
            tap_tx_q <= LOADTAP_C;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req.REQ_VALID && ready_q) begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        sel_q   <= req.REQ_SEL;
                        dir_q   <= (req.REQ_OP == OP_INC);
                        op_q    <= req.REQ_OP;
                        steps_q <= req.REQ_STEPS;
                        if (req.REQ_OP == OP_RSVD) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if ((req.REQ_OP != OP_LOAD) && (req.REQ_STEPS == 8'd0)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pause_q <= 1'b1;
                            cnt_q   <= SETUP_C;
                            state_q <= S_PAUSE_ON;
                        end
                    end
                end
                S_PAUSE_ON: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                S_PULSE: begin
                    load_q  <= 1'b0;
                    move_q  <= 1'b0;
                    cnt_q   <= GAP_C;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    if (oor_sel) begin
                        err_q   <= 1'b1;
                        steps_q <= 8'd0;
                    end
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!launch) begin
                        cnt_q   <= HOLD_C;
                        state_q <= S_PAUSE_OFF;
                    end
                end
                S_PAUSE_OFF: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        pause_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // The range check happens before the pulse, so a tap at its limit never wraps.
            if (launch) begin
                if (op_q == OP_LOAD) begin
                    load_q  <= 1'b1;
                    steps_q <= 8'd0;
                    state_q <= S_PULSE;
                    if (sel_q) tap_tx_q <= tap_d; else tap_rx_q <= tap_d;
                end else if (at_limit) begin
                    err_q   <= 1'b1;
                    cnt_q   <= HOLD_C;
                    state_q <= S_PAUSE_OFF;
                end else begin
                    move_q  <= 1'b1;
                    steps_q <= steps_q - 8'd1;
                    state_q <= S_PULSE;
                    if (sel_q) tap_tx_q <= tap_d; else tap_rx_q <= tap_d;
                end
            end
        end
    end

    assign req.REQ_READY        = ready_q;
    assign req.DONE             = done_q;
    assign req.ERR              = err_q;
    assign TAP_RX               = tap_rx_q;
    assign TAP_TX               = tap_tx_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;
    assign dbg_state_o          = state_q;
endmodule

// File: doc/lanectrl_dly_sequencer.md
Name: lanectrl_dly_sequencer

Overview:
- Sequences DELAY_LINE_* and HS_IO_CLK_PAUSE for one LANECTRL lane (RX or TX delay line) from fabric step requests.
- Brackets every load or move burst with a clock pause and paces the MOVE pulses.
- Tracks the tap position of each delay line and reports range errors.
- Sits between the DDR PHY training/calibration logic and the lane controller instance, in the FAB_CLK domain.

Parameters:
- PAUSE_SETUP, 4: cycles HS_IO_CLK_PAUSE is high before the first LOAD/MOVE pulse (1..15).
- MOVE_GAP, 2: idle cycles after each MOVE/LOAD pulse (1..15).
- PAUSE_HOLD, 4: cycles HS_IO_CLK_PAUSE stays high after the final gap (1..15).
- MAX_TAP, 127: highest legal tap value (8-bit).
- LOAD_TAP, 1: tap value after reset or a LOAD operation.

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- RESET_N  in  1  synchronous active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  sequencer idle, can accept a request.
- REQ_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 reserved.
- REQ_SEL  in  1  0 = RX delay line, 1 = TX delay line.
- REQ_STEPS  in  8  number of MOVE pulses (INC/DEC only).
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky error flag; cleared by the next accepted request.
- TAP_RX  out  8  tracked RX tap position.
- TAP_TX  out  8  tracked TX tap position.
- RX_OOR  in  1  RX_DELAY_LINE_OUT_OF_RANGE from LANECTRL.
- TX_OOR  in  1  TX_DELAY_LINE_OUT_OF_RANGE from LANECTRL.
- DELAY_LINE_SEL  out  1  registered REQ_SEL.
- DELAY_LINE_DIRECTION  out  1  1 = INC, 0 = DEC.
- DELAY_LINE_LOAD  out  1  one-cycle load pulse.
- DELAY_LINE_MOVE  out  1  one-cycle move pulse.
- HS_IO_CLK_PAUSE  out  1  pause request, to the pause synchroniser.

Behaviour:
- Reset (RESET_N low at an edge): state IDLE.
  - REQ_READY=1 from the first edge after release.
  - All pulse outputs, HS_IO_CLK_PAUSE, DONE, ERR, SEL and DIRECTION = 0.
  - TAP_RX = TAP_TX = LOAD_TAP.
  - Reset mid-operation aborts immediately; HS_IO_CLK_PAUSE drops at that edge with no hold. The remaining burst is lost.
- Accept: edge where REQ_VALID & REQ_READY; call it cycle 0. The edge after acceptance is cycle 1; cycle k is k edges after acceptance.
  - REQ_READY falls at cycle 1.
  - SEL and DIRECTION are latched at the accepting edge and held until the next accept.
  - ERR clears at the accepting edge.
- States: IDLE -> PAUSE_ON -> PULSE -> GAP -> (PULSE | PAUSE_OFF) -> DONE -> IDLE.
- PAUSE_ON: HS_IO_CLK_PAUSE=1 from cycle 1 for PAUSE_SETUP cycles.
- PULSE (one cycle):
  - LOAD: DELAY_LINE_LOAD=1; the selected TAP becomes LOAD_TAP.
  - INC/DEC: DELAY_LINE_MOVE=1; the selected TAP changes by ±1 and the remaining-step count decrements.
  - First pulse occurs at cycle 1+PAUSE_SETUP.
- GAP: MOVE_GAP cycles with both pulse outputs low.
  - If steps remain, go to PULSE; pulses are spaced MOVE_GAP+1 cycles apart.
  - Otherwise go to PAUSE_OFF.
- PAUSE_OFF: pause held PAUSE_HOLD more cycles. If the last pulse is at cycle m:
  - HS_IO_CLK_PAUSE falls and DONE=1 at cycle m+MOVE_GAP+PAUSE_HOLD+1.
  - REQ_READY=1 at the following cycle.
- Range check, done before each INC/DEC pulse:
  - INC with TAP==MAX_TAP, or DEC with TAP==0: no pulse is issued, ERR is set, and the state goes to PAUSE_OFF immediately.
  - TAP never wraps.
- OOR: the selected line's OOR input is sampled on every GAP cycle. If high, ERR is set, remaining steps are abandoned, and the state goes to PAUSE_OFF after the current gap. TAP keeps its counted value.
- REQ_STEPS=0 with INC/DEC: no pause and no pulse; DONE at cycle 1, READY at cycle 2.
- REQ_OP=11: ERR set; DONE at cycle 1, no pause.
- DONE fires exactly once per accepted request, including error cases.
- REQ_VALID while busy is ignored, not queued.
- Request inputs are only sampled at acceptance.

Test Plan:
- Reset release -> TAP_RX=TAP_TX=1, READY=1, PAUSE/MOVE/LOAD/DONE/ERR=0.
- INC, SEL=1, STEPS=3, default params ->
  - PAUSE high cycles 1..17.
  - MOVE at cycles 5, 8, 11 with DIRECTION=1, SEL=1.
  - DONE at 18, READY at 19, TAP_TX=4.
- LOAD, SEL=0 after TAP_RX=10 -> LOAD pulse at cycle 5, TAP_RX=1, DONE at 12, no MOVE.
- DEC, STEPS=5 with TAP_RX=2 -> MOVE at cycles 5 and 8, TAP_RX=0, then ERR=1 and DONE at 15.
- INC, STEPS=4, RX_OOR forced high during the gap after the second pulse -> MOVE at 5 and 8 only, TAP_RX+=2, ERR=1, DONE at 15.
- RESET_N low at cycle 6 of an INC burst -> PAUSE=0 at that edge, TAP=1, READY=1 after release. Also: STEPS=0 -> DONE at 1, no PAUSE.
